reg_file_rename: RTL and testbench
==================================

Name: reg_file_rename

Overview:
- Architectural register file with per-register rename tags.
- Consumer end of the reorder buffer's commit port: takes the ROB's commit writes and clears the matching tags.
- Producer end of the commander's operand lookup: returns a value, or the ROB tag the operand is waiting on.
- Records a new rename tag when the commander issues an instruction with a destination, and flushes all tags on a rollback.

Parameters:
- REG_NUM, 32, number of architectural registers; index 0 is hard-wired zero.
- REG_POS_WIDTH, 5, width of a register index.
- DATA_WIDTH, 32, width of a register value.
- ROB_ID_WIDTH, 5, width of a ROB tag. Valid tags are 1..ROB_SIZE.
- INVALID_ROB, 0, tag meaning "value present, not renamed".

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- rdy  in  1  global ready; when low, all state holds.
- rs1_from_cmd  in  REG_POS_WIDTH  source register 1 index.
- rs2_from_cmd  in  REG_POS_WIDTH  source register 2 index.
- Q1_to_cmd  out  ROB_ID_WIDTH  pending tag for rs1, or INVALID_ROB.
- Q2_to_cmd  out  ROB_ID_WIDTH  pending tag for rs2, or INVALID_ROB.
- V1_to_cmd  out  DATA_WIDTH  value of rs1; meaningful only when Q1_to_cmd is INVALID_ROB.
- V2_to_cmd  out  DATA_WIDTH  value of rs2; meaningful only when Q2_to_cmd is INVALID_ROB.
- enable_sign_from_cmd  in  1  issue with destination this cycle.
- rd_from_cmd  in  REG_POS_WIDTH  destination register being renamed.
- rob_id_from_cmd  in  ROB_ID_WIDTH  ROB tag allocated to that destination.
- commit_sign  in  1  ROB commit valid.
- rd_from_rob  in  REG_POS_WIDTH  committed destination.
- Q_from_rob  in  ROB_ID_WIDTH  tag of the committing entry.
- V_from_rob  in  DATA_WIDTH  committed value.
- rollback_sign  in  1  misprediction flush, asserted for one cycle.

Behaviour:
- State:
  - value[REG_NUM], DATA_WIDTH each.
  - tag[REG_NUM], ROB_ID_WIDTH each.
- Reset (rst low, asynchronous): all value = 0, all tag = INVALID_ROB.
  - Outputs, being combinational, read Q* = INVALID_ROB and V* = 0 during and after reset.
- Reads are combinational, zero latency. Priority per operand:
  - (a) Index 0: Q = INVALID_ROB, V = 0.
  - (b) Bypass: commit_sign high, rd_from_rob == rs, and tag[rs] == Q_from_rob: Q = INVALID_ROB, V = V_from_rob.
  - (c) Otherwise: Q = tag[rs], V = value[rs].
  - Reads never see a same-cycle rename; the commander issues strictly after its own operand lookup.
- Sequential update, when rdy is high, at each rising edge:
  - Commit: if commit_sign and rd_from_rob != 0, then value[rd_from_rob] <= V_from_rob.
    - The commit value is written regardless of tag match; the ROB commits in program order, so the latest commit is architecturally correct.
  - Tag clear: if commit_sign, rd_from_rob != 0, and tag[rd_from_rob] == Q_from_rob, then tag <= INVALID_ROB.
    - A tag mismatch means a younger rename exists; the tag is kept.
  - Rename: if enable_sign_from_cmd, rd_from_cmd != 0, and rollback_sign low, then tag[rd_from_cmd] <= rob_id_from_cmd.
    - Rename overrides a same-cycle tag clear of the same register.
  - Rollback: if rollback_sign, all tags <= INVALID_ROB.
    - A same-cycle commit value write still takes effect (the branch/jal commits with the rollback).
    - Any same-cycle rename is discarded.
  - rdy low: no state change. Reads remain active.
- Writes or renames to register 0 are silently dropped, and tag[0] is never anything but INVALID_ROB.
- No handshakes or backpressure. Inputs are sampled every rdy-high cycle.
- Target implementation size: 120–200 lines.

Test Plan:
- Reset, then read x5 -> Q1 = 0, V1 = 0. Commit rd=5, Q=3, V=0x1234 with tag[5] invalid -> next cycle V1 = 0x1234, Q1 = 0.
- Rename x7 to tag 4; next cycle read x7 -> Q1 = 4. Commit rd=7, Q=4, V=0xAA -> same-cycle bypass gives Q1 = 0, V1 = 0xAA; after the edge tag[7] = 0 and value = 0xAA.
- Rename x7 to 4, then rename x7 to 9. Commit rd=7, Q=4, V=0x11 -> value[7] = 0x11, tag stays 9, read returns Q = 9.
- Same cycle: commit rd=8, Q=2 (tag[8] = 2) and rename x8 to 6 -> tag[8] = 6, value[8] = commit value.
- Rename x1, x2, x3 to tags 1, 2, 3, then rollback with commit rd=1, Q=1, V=0x40 and rename x4 to 5 -> all tags 0, value[1] = 0x40, tag[4] = 0.
- Rename x0 and commit rd=0, V=0xFF -> read x0 gives Q = 0, V = 0.
- Hold rdy low with commit and rename asserted -> no state change.
- Drop rst mid-cycle -> state clears immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file_rename_if.sv
// Operand-lookup, rename and ROB-commit signals shared between the
// commander/ROB side (master) and the register file (slave).
interface reg_file_rename_if #(
    parameter int REG_POS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_ID_WIDTH  = 5
);
  logic [REG_POS_WIDTH-1:0] rs1_from_cmd;
  logic [REG_POS_WIDTH-1:0] rs2_from_cmd;
  logic [ROB_ID_WIDTH-1:0]  Q1_to_cmd;
  logic [ROB_ID_WIDTH-1:0]  Q2_to_cmd;
  logic [DATA_WIDTH-1:0]    V1_to_cmd;
  logic [DATA_WIDTH-1:0]    V2_to_cmd;
  logic                     enable_sign_from_cmd;
  logic [REG_POS_WIDTH-1:0] rd_from_cmd;
  logic [ROB_ID_WIDTH-1:0]  rob_id_from_cmd;
  logic                     commit_sign;
  logic [REG_POS_WIDTH-1:0] rd_from_rob;
  logic [ROB_ID_WIDTH-1:0]  Q_from_rob;
  logic [DATA_WIDTH-1:0]    V_from_rob;
  logic                     rollback_sign;

  modport master (
    output rs1_from_cmd, rs2_from_cmd,
    input  Q1_to_cmd, Q2_to_cmd, V1_to_cmd, V2_to_cmd,
    output enable_sign_from_cmd, rd_from_cmd, rob_id_from_cmd,
    output commit_sign, rd_from_rob, Q_from_rob, V_from_rob,
    output rollback_sign
  );

  modport slave (
    input  rs1_from_cmd, rs2_from_cmd,
    output Q1_to_cmd, Q2_to_cmd, V1_to_cmd, V2_to_cmd,
    input  enable_sign_from_cmd, rd_from_cmd, rob_id_from_cmd,
    input  commit_sign, rd_from_rob, Q_from_rob, V_from_rob,
    input  rollback_sign
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags, commit-time
// tag clearing with read bypass, and whole-table tag flush on rollback.
module reg_file_rename #(
    parameter int REG_NUM       = 32,
    parameter int REG_POS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_ID_WIDTH  = 5
) (
    input logic              clk,
    input logic              rst,
    input logic              rdy,
    reg_file_rename_if.slave bus
);

  localparam logic [ROB_ID_WIDTH-1:0]  INVALID_ROB = {ROB_ID_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]    ZERO_DATA   = {DATA_WIDTH{1'b0}};
  localparam logic [REG_POS_WIDTH-1:0] ZERO_REG    = {REG_POS_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0]   value_q [REG_NUM];
  logic [DATA_WIDTH-1:0]   value_d [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] tag_q   [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] tag_d   [REG_NUM];

  logic commit_hit_s;

  assign commit_hit_s = bus.commit_sign && (bus.rd_from_rob != ZERO_REG);

  // Operand lookup: x0 reads zero, a matching commit bypasses into the read.
  always_comb begin
    bus.Q1_to_cmd = INVALID_ROB;
    bus.V1_to_cmd = ZERO_DATA;
    bus.Q2_to_cmd = INVALID_ROB;
    bus.V2_to_cmd = ZERO_DATA;
    if (bus.rs1_from_cmd == ZERO_REG) begin
      bus.Q1_to_cmd = INVALID_ROB;
    end else if (bus.commit_sign && (bus.rd_from_rob == bus.rs1_from_cmd) &&
                 (tag_q[bus.rs1_from_cmd] == bus.Q_from_rob)) begin
      bus.V1_to_cmd = bus.V_from_rob;
    end else begin
      bus.Q1_to_cmd = tag_q[bus.rs1_from_cmd];
      bus.V1_to_cmd = value_q[bus.rs1_from_cmd];
    end
    if (bus.rs2_from_cmd == ZERO_REG) begin
      bus.Q2_to_cmd = INVALID_ROB;
    end else if (bus.commit_sign && (bus.rd_from_rob == bus.rs2_from_cmd) &&
                 (tag_q[bus.rs2_from_cmd] == bus.Q_from_rob)) begin
      bus.V2_to_cmd = bus.V_from_rob;
    end else begin
      bus.Q2_to_cmd = tag_q[bus.rs2_from_cmd];
      bus.V2_to_cmd = value_q[bus.rs2_from_cmd];
    end
  end

  // Next state: commit write and tag clear, then rename (which wins over the
  // clear) unless a rollback flushes every tag this cycle.
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      value_d[i] = value_q[i];
      tag_d[i]   = tag_q[i];
    end
    if (rdy) begin
      if (commit_hit_s) begin
        value_d[bus.rd_from_rob] = bus.V_from_rob;
        if (tag_q[bus.rd_from_rob] == bus.Q_from_rob) begin
          tag_d[bus.rd_from_rob] = INVALID_ROB;
        end else begin
          tag_d[bus.rd_from_rob] = tag_q[bus.rd_from_rob];
        end
      end else begin
        value_d[0] = ZERO_DATA;
      end
      if (bus.rollback_sign) begin
        for (int i = 0; i < REG_NUM; i++) begin
          tag_d[i] = INVALID_ROB;
        end
      end else if (bus.enable_sign_from_cmd && (bus.rd_from_cmd != ZERO_REG)) begin
        tag_d[bus.rd_from_cmd] = bus.rob_id_from_cmd;
      end else begin
        tag_d[0] = INVALID_ROB;
      end
    end else begin
      value_d[0] = ZERO_DATA;
    end
    value_d[0] = ZERO_DATA;
    tag_d[0]   = INVALID_ROB;
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= ZERO_DATA;
        tag_q[i]   <= INVALID_ROB;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed and randomized checks of reg_file_rename against an array-based
// model of the architectural values and rename tags.
module tb_reg_file_rename;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  reg_file_rename_if #(.REG_POS_WIDTH(5), .DATA_WIDTH(32), .ROB_ID_WIDTH(5)) bus ();

  reg_file_rename #(
      .REG_NUM(32), .REG_POS_WIDTH(5), .DATA_WIDTH(32), .ROB_ID_WIDTH(5)
  ) dut (
      .clk(clk),
      .rst(rst),
      .rdy(rdy),
      .bus(bus.slave)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [31:0] mv[32];
  logic [4:0]  mt[32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 32'd0;
      mt[i] = 5'd0;
    end
  endtask

  task automatic model_read(input logic [4:0] rs, output logic [4:0] q, output logic [31:0] v);
    if (rs == 5'd0) begin
      q = 5'd0; v = 32'd0;
    end else if (bus.commit_sign && bus.rd_from_rob == rs && mt[rs] == bus.Q_from_rob) begin
      q = 5'd0; v = bus.V_from_rob;
    end else begin
      q = mt[rs]; v = mv[rs];
    end
  endtask

  task automatic model_edge();
    logic clr;
    if (rdy) begin
      clr = (mt[bus.rd_from_rob] == bus.Q_from_rob);
      if (bus.commit_sign && bus.rd_from_rob != 5'd0) begin
        mv[bus.rd_from_rob] = bus.V_from_rob;
        if (clr) mt[bus.rd_from_rob] = 5'd0;
      end
      if (bus.rollback_sign) begin
        for (int i = 0; i < 32; i++) mt[i] = 5'd0;
      end else if (bus.enable_sign_from_cmd && bus.rd_from_cmd != 5'd0) begin
        mt[bus.rd_from_cmd] = bus.rob_id_from_cmd;
      end
    end
  endtask

  task automatic drive(input bit en, input logic [4:0] rdc, input logic [4:0] id,
                       input bit cm, input logic [4:0] rdr, input logic [4:0] q,
                       input logic [31:0] v, input bit rb, input bit r);
    bus.enable_sign_from_cmd = en;
    bus.rd_from_cmd          = rdc;
    bus.rob_id_from_cmd      = id;
    bus.commit_sign          = cm;
    bus.rd_from_rob          = rdr;
    bus.Q_from_rob           = q;
    bus.V_from_rob           = v;
    bus.rollback_sign        = rb;
    rdy                      = r;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1);
  endtask

  // Check both read ports against the model, then advance one clock.
  task automatic step();
    logic [4:0]  eq;
    logic [31:0] ev;
    #1;
    model_read(bus.rs1_from_cmd, eq, ev);
    check_eq("q1", {27'd0, bus.Q1_to_cmd}, {27'd0, eq});
    check_eq("v1", bus.V1_to_cmd, ev);
    model_read(bus.rs2_from_cmd, eq, ev);
    check_eq("q2", {27'd0, bus.Q2_to_cmd}, {27'd0, eq});
    check_eq("v2", bus.V2_to_cmd, ev);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [4:0] rs, input logic [4:0] eq,
                      input logic [31:0] ev);
    bus.rs1_from_cmd = rs;
    #1;
    check_eq({tag, "_q"}, {27'd0, bus.Q1_to_cmd}, {27'd0, eq});
    check_eq({tag, "_v"}, bus.V1_to_cmd, ev);
  endtask

  initial begin
    logic [4:0] rdr;
    logic [4:0] qq;
    rst = 1'b0;
    bus.rs1_from_cmd = 5'd0;
    bus.rs2_from_cmd = 5'd0;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    peek("in_reset", 5'd5, 5'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    peek("reset_x5", 5'd5, 5'd0, 32'd0);

    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 5'd3, 32'h1234, 1'b0, 1'b1); step();
    idle(); peek("commit_x5", 5'd5, 5'd0, 32'h1234);

    drive(1'b1, 5'd7, 5'd4, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1); step();
    idle(); peek("rename_x7", 5'd7, 5'd4, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd4, 32'hAA, 1'b0, 1'b1);
    peek("bypass_x7", 5'd7, 5'd0, 32'hAA);
    step();
    idle(); peek("after_bypass_x7", 5'd7, 5'd0, 32'hAA);

    drive(1'b1, 5'd7, 5'd4, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1); step();
    drive(1'b1, 5'd7, 5'd9, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1); step();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd4, 32'h11, 1'b0, 1'b1); step();
    idle(); peek("stale_commit_x7", 5'd7, 5'd9, 32'h11);

    drive(1'b1, 5'd8, 5'd2, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1); step();
    drive(1'b1, 5'd8, 5'd6, 1'b1, 5'd8, 5'd2, 32'h77, 1'b0, 1'b1); step();
    idle(); peek("rename_over_clear", 5'd8, 5'd6, 32'h77);

    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 5'(i), 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1); step();
    end
    drive(1'b1, 5'd4, 5'd5, 1'b1, 5'd1, 5'd1, 32'h40, 1'b1, 1'b1); step();
    idle();
    peek("rollback_x1", 5'd1, 5'd0, 32'h40);
    peek("rollback_x3", 5'd3, 5'd0, 32'd0);
    peek("rollback_x4", 5'd4, 5'd0, 32'd0);

    drive(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 5'd0, 32'hFF, 1'b0, 1'b1); step();
    idle(); peek("x0", 5'd0, 5'd0, 32'd0);

    drive(1'b1, 5'd9, 5'd7, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b1); step();
    drive(1'b1, 5'd10, 5'd8, 1'b1, 5'd9, 5'd7, 32'h55, 1'b0, 1'b0); step();
    idle();
    peek("rdy_low_x9", 5'd9, 5'd7, 32'd0);
    peek("rdy_low_x10", 5'd10, 5'd0, 32'd0);

    for (int n = 0; n < 400; n++) begin
      rdr = 5'($urandom_range(0, 31));
      qq = ($urandom_range(0, 3) != 0 && mt[rdr] != 5'd0) ? mt[rdr]
                                                          : 5'($urandom_range(1, 31));
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)),
            $urandom_range(0, 1) == 1, rdr, qq, $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) bus.rs1_from_cmd = rdr;
      else bus.rs1_from_cmd = 5'($urandom_range(0, 31));
      bus.rs2_from_cmd = 5'($urandom_range(0, 31));
      step();
    end

    drive(1'b1, 5'd11, 5'd3, 1'b1, 5'd12, 5'd1, 32'h99, 1'b0, 1'b1); step();
    idle();
    bus.rs2_from_cmd = 5'd11;
    peek("pre_async_x12", 5'd12, mt[12], 32'h99);
    #1 rst = 1'b0;
    #1;
    check_eq("async_v12", bus.V1_to_cmd, 32'd0);
    check_eq("async_q11", {27'd0, bus.Q2_to_cmd}, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    bus.rs1_from_cmd = 5'd12;
    step();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
